// File: rtl/io_output_arbiter_pkg.sv
// Package for io_output_arbiter: word width and arbiter state type built
// from the shared defines.
`include "io_output_arbiter_defines.sv"

package io_output_arbiter_pkg;

    localparam int WORD_W = `WORD_SIZE;

    typedef enum logic [`ARB_STATE_BITS-1:0] {
        ARB_IDLE = `ARB_ST_IDLE,
        ARB_REQ  = `ARB_ST_REQ,
        ARB_ACK  = `ARB_ST_ACK,
        ARB_REL  = `ARB_ST_REL
    } arb_state_t;

endpackage

// File: rtl/io_arb_pick.sv
// Winner selection for io_output_arbiter.
// With IO_ARB_ROUND_ROBIN_EN defined the search starts at ptr+1 and wraps;
// otherwise the lowest requesting index wins and ptr is ignored.
module io_arb_pick
    import io_output_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] j;

`ifdef IO_ARB_ROUND_ROBIN_EN
    // walk from the farthest candidate back to ptr+1 so the nearest one wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // walk from the top index down so the lowest requester wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = IW'(i);
            if (req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end
`endif

endmodule

// File: rtl/io_output_arbiter_defines.sv
// Shared defines for the output arbiter slice: data word size, the
// four-phase handshake phase constants and the arbiter state encodings.
`ifndef IO_OUTPUT_ARBITER_DEFINES
`define IO_OUTPUT_ARBITER_DEFINES

`define WORD_SIZE 8

// four-phase handshake phases as seen on any req/ack pair
`define IO_HS_IDLE 2'd0
`define IO_HS_REQ  2'd1
`define IO_HS_ACK  2'd2
`define IO_HS_REL  2'd3

// arbiter FSM encodings
`define ARB_STATE_BITS 2
`define ARB_ST_IDLE 2'd0
`define ARB_ST_REQ  2'd1
`define ARB_ST_ACK  2'd2
`define ARB_ST_REL  2'd3

`endif

// File: rtl/io_output_arbiter.sv
// io_output_arbiter: N requesters sharing one output device, all links
// four-phase req/ack. Define IO_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; the default build uses fixed lowest-index priority.
//
// state    | meaning
// ARB_IDLE | waiting for a request with the device released (down_ack=0)
// ARB_REQ  | word latched, down_req high, waiting for down_ack
// ARB_ACK  | device accepted; up_ack to winner until it drops up_req
// ARB_REL  | down_req low, waiting for the device to drop down_ack
`include "io_output_arbiter_defines.sv"

module io_output_arbiter
    import io_output_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic [N_REQ-1:0]            up_req,
    input  logic [N_REQ*`WORD_SIZE-1:0] up_data,
    output logic [N_REQ-1:0]            up_ack,
    output logic                        down_req,
    output logic [`WORD_SIZE-1:0]       down_data,
    input  logic                        down_ack,
    output logic [$clog2(N_REQ)-1:0]    grant_id
);
    localparam int IW = $clog2(N_REQ);

    arb_state_t        state, state_nxt;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [WORD_W-1:0] pick_data;
    logic              load;

    // grant_id doubles as the round-robin pointer
    io_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (up_req),
        .ptr   (grant_id),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_data = up_data[int'(pick_idx)*WORD_W +: WORD_W];

    // state register
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // winner index and its word captured only when leaving idle
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            down_data <= '0;
            grant_id  <= IW'(N_REQ - 1);
        end else if (load) begin
            down_data <= pick_data;
            grant_id  <= pick_idx;
        end
    end

    // next state and handshake outputs; outputs decode state only so reset clears them at once
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        down_req  = 1'b0;
        up_ack    = '0;
        case (state)
            ARB_IDLE: begin
                // a device still holding ack from before must release first
                if (pick_valid && !down_ack) begin
                    load      = 1'b1;
                    state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                down_req = 1'b1;
                if (down_ack) begin
                    state_nxt = ARB_ACK;
                end
            end
            ARB_ACK: begin
                down_req         = 1'b1;
                up_ack[grant_id] = 1'b1;
                if (!up_req[grant_id]) begin
                    state_nxt = ARB_REL;
                end
            end
            ARB_REL: begin
                if (!down_ack) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_output_arbiter.sv
// Bench for io_output_arbiter: requester and device models drive the ports,
// a reference arbiter pushes each expected grant into a queue and a monitor
// pops and compares whenever down_req rises.
module tb_io_output_arbiter;
    localparam int N = 4;
    localparam int W = 8;
`ifdef IO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             areset = 1'b0;
    logic [N-1:0]     up_req = '0;
    logic [N*W-1:0]   up_data = '0;
    logic [N-1:0]     up_ack;
    logic             down_req;
    logic [W-1:0]     down_data;
    logic             down_ack = 1'b0;
    logic [1:0]       grant_id;

    io_output_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .areset    (areset),
        .up_req    (up_req),
        .up_data   (up_data),
        .up_ack    (up_ack),
        .down_req  (down_req),
        .down_data (down_data),
        .down_ack  (down_ack),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    logic [N-1:0] held = '0;
    logic [W-1:0] data [N];
    int           last_g = N - 1;
    int           cur_w = 0;
    int           last_obs = -1;
    int           dev_lat = 0;
    bit           dev_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arbiter written from the selection rules
    function automatic int model_pick(input logic [N-1:0] r, input int last);
        if (RR) begin
            for (int k = 1; k <= N; k++) begin
                if (r[(last + k) % N]) return (last + k) % N;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic drive();
        up_req = held;
        for (int i = 0; i < N; i++) up_data[i*W +: W] = data[i];
    endtask

    task automatic push_exp();
        exp_t e;
        e.id   = model_pick(held, last_g);
        e.data = data[e.id];
        exp_q.push_back(e);
        last_g = e.id;
        cur_w  = e.id;
    endtask

    // 0: down_req high, 1: any up_ack, 2: down_req low, 3: fully quiet
    task automatic wait_for(input int what, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            case (what)
                0: if (down_req === 1'b1) return;
                1: if (up_ack !== '0) return;
                2: if (down_req === 1'b0) return;
                default: if (down_req === 1'b0 && down_ack === 1'b0 && up_ack === '0) return;
            endcase
        end
        compared++;
        mismatched++;
        $display("FAIL timeout_%s: condition not reached in 200 cycles, got down_req=%b up_ack=%b", name, down_req, up_ack);
    endtask

    task automatic start(input logic [N-1:0] bits, input bit fix, input logic [W-1:0] val);
        for (int i = 0; i < N; i++) begin
            if (bits[i] && !held[i]) data[i] = fix ? val : W'($urandom);
        end
        held |= bits;
        drive();
        push_exp();
    endtask

    // one transfer for the already-predicted winner; next prediction made during release
    task automatic serve(input int lat, input bit early, input bit chg, input bit add_mid,
                         input logic [N-1:0] next_add, input bit rearm, input logic [N-1:0] keep);
        int           w;
        logic [N-1:0] nb;
        w       = cur_w;
        dev_lat = lat;
        wait_for(0, "grant");
        if (chg) begin
            data[w] = data[w] + 1'b1;
            drive();
        end
        if (early) begin
            held[w] = 1'b0;
            drive();
        end
        if (add_mid) begin
            nb = N'($urandom) & ~held & ~(N'(1) << w);
            for (int i = 0; i < N; i++) if (nb[i]) data[i] = W'($urandom);
            held |= nb;
            drive();
        end
        wait_for(1, "ack");
        held[w] = 1'b0;
        drive();
        wait_for(2, "release");
        held &= keep;
        nb = (next_add | (rearm ? (N'(1) << w) : N'(0))) & ~held;
        for (int i = 0; i < N; i++) if (nb[i]) data[i] = W'($urandom);
        held |= nb;
        drive();
        if (held != '0) push_exp();
        else wait_for(3, "idle");
    endtask

    // output device: ack after dev_lat cycles, release after a random pause
    initial begin
        int cnt;
        int rel;
        cnt = 0;
        rel = 0;
        forever begin
            @(posedge clk); #1;
            if (dev_en) begin
                if (down_req && !down_ack) begin
                    if (cnt >= dev_lat) begin
                        down_ack = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else if (!down_req && down_ack) begin
                    if (rel > 0) rel--;
                    else begin
                        down_ack = 1'b0;
                        rel = $urandom_range(0, 2);
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // monitor: pop on each new grant, then watch data and ack while it lasts
    initial begin
        exp_t cur;
        logic prev;
        cur.id   = 0;
        cur.data = '0;
        prev     = 1'b0;
        forever begin
            @(negedge clk);
            if (areset !== 1'b1) begin
                prev = 1'b0;
            end else begin
                if (down_req === 1'b1 && prev !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_grant: grant_id=%0d appeared with no grant predicted", grant_id);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_id", grant_id, cur.id);
                        chk("grant_data", down_data, cur.data);
                        last_obs = grant_id;
                    end
                end
                if (down_req === 1'b1) chk("data_hold", down_data, cur.data);
                if (up_ack !== '0) begin
                    chk("ack_onehot", $countones(up_ack), 1);
                    chk("ack_vec", up_ack, 1 << cur.id);
                    chk("ack_with_dreq", down_req, 1);
                end
                prev = down_req;
            end
        end
    end

    initial begin
        #500000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) data[i] = '0;

        // reset values
        #12;
        chk("rst_up_ack", up_ack, 0);
        chk("rst_down_req", down_req, 0);
        chk("rst_down_data", down_data, 0);
        chk("rst_grant_id", grant_id, N - 1);
        @(posedge clk); #2;
        areset = 1'b1;

        // contention with all four held, then wrap-around from 3 with 1001
        start(4'b1111, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            serve(1, 1'b0, 1'b0, 1'b0, '0, 1'b1, '1);
            chk("contention_order", last_obs, RR ? k : 0);
        end
        serve(1, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 4'b1001);
        chk("contention_order", last_obs, RR ? 3 : 0);
        serve(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        chk("wrap_grant", last_obs, 0);
        while (held != '0) serve(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        wait_for(3, "idle");

        // single request, device acks after 3 cycles
        start(4'b0010, 1'b1, 8'h41);
        serve(3, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        chk("single_grant_id", grant_id, 1);
        chk("single_data", down_data, 8'h41);
        chk("single_idle_dreq", down_req, 0);

        // data change after grant must not reach down_data
        start(4'b0100, 1'b1, 8'h30);
        serve(2, 1'b0, 1'b1, 1'b0, '0, 1'b0, '1);
        chk("stable_after_release", down_data, 8'h30);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if (held == '0) start(N'($urandom_range(1, 15)), 1'b0, '0);
            serve($urandom_range(0, 4), ($urandom % 4) == 0, $urandom % 2, $urandom % 2,
                  (($urandom % 3) == 0) ? N'(0) : N'($urandom), 1'b0, '1);
        end
        while (held != '0) serve(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        wait_for(3, "idle");

        // device ack stuck high in idle blocks any grant
        dev_en   = 1'b0;
        down_ack = 1'b1;
        data[0]  = W'($urandom);
        held     = 4'b0001;
        drive();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            chk("stuck_no_grant", down_req, 0);
        end
        push_exp();
        down_ack = 1'b0;
        dev_en   = 1'b1;
        serve(1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        chk("stuck_then_grant", last_obs, 0);
        wait_for(3, "idle");

        // reset in the middle of an acknowledge
        start(4'b0010, 1'b0, '0);
        dev_lat = 1;
        wait_for(0, "rst_grant");
        wait_for(1, "rst_ack");
        areset = 1'b0;
        #1;
        chk("rst_mid_up_ack", up_ack, 0);
        chk("rst_mid_down_req", down_req, 0);
        chk("rst_mid_grant_id", grant_id, N - 1);
        chk("rst_mid_down_data", down_data, 0);
        held = '0;
        drive();
        exp_q.delete();
        last_g = N - 1;
        repeat (3) @(posedge clk);
        #2;
        start(4'b0100, 1'b0, '0);
        @(posedge clk); #2;
        areset = 1'b1;
        #1;
        chk("rst_release_no_grant", down_req, 0);
        serve(2, 1'b0, 1'b0, 1'b0, '0, 1'b0, '1);
        chk("post_rst_grant", last_obs, 2);
        wait_for(3, "idle");

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/io_output_arbiter.md
IO_OUTPUT_ARBITER -- requirements
Module: io_output_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port areset, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port up_req, input, N_REQ bits, meaning the per-requester four-phase request.
REQ-005 SHALL have port up_data, input, N_REQ*`WORD_SIZE bits, meaning the per-requester output word; requester i occupies slice [i*`WORD_SIZE +: `WORD_SIZE].
REQ-006 SHALL have port up_ack, output, N_REQ bits, meaning the per-requester four-phase acknowledge.
REQ-007 SHALL have port down_req, output, 1 bit, meaning the request to the output device.
REQ-008 SHALL have port down_data, output, `WORD_SIZE bits, meaning the word presented to the output device.
REQ-009 SHALL have port down_ack, input, 1 bit, meaning the acknowledge from the output device.
REQ-010 SHALL have port grant_id, output, $clog2(N_REQ) bits, meaning the index of the current or last granted requester.

Function
REQ-011 SHALL run FSM states ARB_IDLE, ARB_REQ, ARB_ACK and ARB_REL, held in a registered state with a combinational next-state.
REQ-012 ARB_IDLE: if any up_req bit is high, SHALL select a winner, latch its up_data into down_data, set grant_id, and go to ARB_REQ on the next edge.
REQ-013 ARB_REQ: SHALL drive down_req=1 and hold down_data stable; on down_ack=1 SHALL go to ARB_ACK.
REQ-014 ARB_ACK: SHALL drive up_ack[grant_id]=1 and keep down_req=1; on up_req[grant_id]=0 SHALL go to ARB_REL.
REQ-015 ARB_REL: SHALL drive down_req=0 and up_ack all 0; on down_ack=0 SHALL go to ARB_IDLE.
REQ-016 At most one up_ack bit SHALL be high in any cycle, and only in ARB_ACK.
REQ-017 down_req SHALL be high exactly in ARB_REQ and ARB_ACK.
REQ-018 Minimum latency from up_req rise to up_ack rise SHALL be 2 cycles plus device latency (IDLE->REQ 1 cycle, REQ->ACK on down_ack).
REQ-019 A requester change of up_data after grant SHALL NOT affect down_data until the next grant.
REQ-020 Requests from non-granted requesters SHALL be ignored until ARB_IDLE, and SHALL NOT be lost while held.
REQ-021 A requester dropping up_req before its ack SHALL NOT abort the transfer; the FSM SHALL still complete ARB_ACK and ARB_REL.
REQ-022 down_ack=1 while in ARB_IDLE SHALL NOT start a grant; the FSM SHALL remain in ARB_IDLE until down_ack=0 and a request is present.

Reset
REQ-023 areset=0 SHALL asynchronously force: state ARB_IDLE, up_ack=0, down_req=0, down_data=0, grant_id=N_REQ-1, and the round-robin pointer to N_REQ-1.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no up_ack pulse; the first grant after reset release SHALL take at least one clk edge.

Configuration
REQ-025 With `IO_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index searching upward, with wrap-around, from grant_id+1.
REQ-026 Without `IO_ARB_ROUND_ROBIN_EN, the winner SHALL be the lowest requesting index (fixed priority), and grant_id SHALL still report the winner.

Structure
REQ-027 `WORD_SIZE and the four ARB_* state encodings (new `ARB_STATE_BITS, 2 bits) SHALL live in the shared defines.vh, alongside the IO_* handshake state constants.
REQ-028 The winner selection SHALL be one sub-module, io_arb_pick (inputs: request vector, pointer; outputs: valid, index), instantiated once.

Verification
REQ-029 Single request: N_REQ=4, up_req=0b0010, up_data[1]=8'h41, device acks after 3 cycles -> down_data=8'h41, grant_id=1, up_ack=0b0010, FSM returns to ARB_IDLE after up_req and down_ack fall.
REQ-030 Contention (RR): up_req=0b1111 held, with four transfers -> grant order 0,1,2,3 after reset; without the macro -> order 0,0,0,0.
REQ-031 Wrap-around: grant_id=3, up_req=0b1001 -> next grant is 0 (RR), not 3.
REQ-032 Data stability: change up_data[2] from 8'h30 to 8'h31 while in ARB_REQ -> down_data stays 8'h30 until ARB_IDLE.
REQ-033 Reset mid-transfer: areset=0 while in ARB_ACK -> up_ack=0, down_req=0 immediately, without waiting for clk; grant_id=3.
REQ-034 Stuck down_ack=1 in ARB_IDLE with up_req=0b0001 -> no grant until down_ack=0; then normal transfer.
